beam_idx_sched: RTL and testbench

// - Control-side driver of the per-beam codeword selector: generates ROM-load enable, symbol index/phase, slot clear, first-symbol flag, RBG load strobe and per-beam indices.
// - Buffers sorted beam-index vectors from the beam-sort stage in a FIFO; issues one vector per RBG tick, timed so indices settle one cycle before the load strobe.
// - Sits between beam sorting and codeword selection in the PUSCH dimension-reduction path.

---
 rtl/pusch_dr_pkg.sv | 20 ++
 rtl/beam_idx_fifo.sv | 58 +++++
 rtl/beam_idx_sched.sv | 176 +++++++++++++++++
 tb/tb_beam_idx_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pusch_dr_pkg.sv
// Shared types and default constants for the PUSCH dimension-reduction
// control path (beam index scheduler and its FIFO).
package pusch_dr_pkg;

  localparam int DEF_BEAM     = 16;
  localparam int DEF_IDXW     = 8;
  localparam int DEF_NUM_CW   = 64;
  localparam int DEF_FIX_SYMS = 4;
  localparam int DEF_SYMBS    = 14;
  localparam int DEF_FIFO_DEP = 16;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  typedef logic [DEF_BEAM-1:0][DEF_IDXW-1:0] beam_idx_vec_t;

endpackage

// File: rtl/beam_idx_fifo.sv
// Synchronous FIFO for sorted beam-index vectors. The read data is
// registered and only changes on a pop, so it holds the last popped vector.
// Full and empty come from comparing pointers that carry one extra MSB.
module beam_idx_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  // Pointer update; a flush empties the FIFO and overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; when full with a simultaneous pop the head slot is
  // overwritten, but the read below still captures the old contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Registered read data, updated only when a vector is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= '0;
    else if (do_pop) rd_data <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/beam_idx_sched.sv
// Beam index scheduler: requests the codeword ROM load, tracks the symbol
// index within a slot and issues one buffered beam-index vector per RBG tick,
// with indices valid one cycle ahead of the load strobe.
// Optional macro BEAM_IDX_CHECK_EN: out-of-range indices are replaced by the
// beam number and the sticky o_idx_err output is added.
module beam_idx_sched
  import pusch_dr_pkg::*;
#(
  parameter int BEAM     = DEF_BEAM,
  parameter int IDXW     = DEF_IDXW,
`ifdef BEAM_IDX_CHECK_EN
  parameter int NUM_CW   = DEF_NUM_CW,
`endif
  parameter int FIX_SYMS = DEF_FIX_SYMS,
  parameter int SYMBS    = DEF_SYMBS,
  parameter int FIFO_DEP = DEF_FIFO_DEP
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cw_tvalid,
  input  logic                 i_slot_start,
  input  logic                 i_sym_start,
  input  logic                 i_rbg_tick,
  input  logic                 i_sort_vld,
  input  logic [BEAM*IDXW-1:0] i_sort_beam_idx,
  output logic                 o_sort_rdy,
  output logic                 o_enable,
  output logic [7:0]           o_symb_idx,
  output logic                 o_symb_clr,
  output logic                 o_symb_1st,
  output logic [BEAM*IDXW-1:0] o_beam_idx,
  output logic                 o_rbg_load,
  output logic                 o_underflow,
  output logic                 o_overflow
`ifdef BEAM_IDX_CHECK_EN
  ,
  output logic                 o_idx_err
`endif
);

  localparam logic [7:0] SYM_LAST = 8'(SYMBS - 1);
  localparam logic [7:0] FIX_LIM  = 8'(FIX_SYMS);

  sched_state_e          state;
  sched_state_e          state_nxt;
  logic                  enable_nxt;
  logic                  slot_evt;
  logic                  tick_ok;
  logic                  pop;
  logic                  push;
  logic                  pop_d1;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [BEAM*IDXW-1:0]  fifo_dout;
  logic [7:0]            symb_inc;

  assign slot_evt   = i_slot_start && (state != LOAD);
  assign tick_ok    = (state == RUN) && i_rbg_tick && !o_symb_1st && !i_slot_start;
  assign pop        = tick_ok && !fifo_empty;
  assign push       = i_sort_vld && (state != LOAD);
  assign o_sort_rdy = !fifo_full && (state != LOAD);
  assign symb_inc   = (o_symb_idx < SYM_LAST) ? (o_symb_idx + 8'd1) : o_symb_idx;

  beam_idx_fifo #(
    .WIDTH (BEAM*IDXW),
    .DEPTH (FIFO_DEP)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_reset),
    .flush   (slot_evt),
    .push    (push),
    .pop     (pop),
    .wr_data (i_sort_beam_idx),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register and the registered ROM load enable.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= LOAD;
      o_enable <= 1'b0;
    end else begin
      state    <= state_nxt;
      o_enable <= enable_nxt;
    end
  end

  // Next-state logic; the enable stays high for as long as we remain in LOAD.
  always_comb begin
    state_nxt  = state;
    enable_nxt = 1'b0;
    unique case (state)
      LOAD:    if (i_cw_tvalid)  state_nxt = WAIT;
      WAIT:    if (i_slot_start) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
    enable_nxt = (state_nxt == LOAD);
  end

  // Symbol index, slot clear pulse and fixed-phase flag; slot start wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_symb_idx <= 8'd0;
      o_symb_clr <= 1'b0;
      o_symb_1st <= 1'b1;
    end else if (slot_evt) begin
      o_symb_idx <= 8'd0;
      o_symb_clr <= 1'b1;
      o_symb_1st <= 1'b1;
    end else begin
      o_symb_clr <= 1'b0;
      if ((state == RUN) && i_sym_start) begin
        o_symb_idx <= symb_inc;
        o_symb_1st <= (symb_inc < FIX_LIM);
      end
    end
  end

  // Two-stage pop delay so the strobe trails the index update by one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pop_d1     <= 1'b0;
      o_rbg_load <= 1'b0;
    end else begin
      pop_d1     <= pop;
      o_rbg_load <= pop_d1;
    end
  end

`ifdef BEAM_IDX_CHECK_EN
  localparam logic [IDXW:0] CW_LIM = (IDXW+1)'(NUM_CW);

  logic [BEAM-1:0] idx_bad;

  // Replace any out-of-range index with its own beam number.
  always_comb begin
    o_beam_idx = fifo_dout;
    idx_bad    = '0;
    for (int i = 0; i < BEAM; i++) begin
      if ({1'b0, fifo_dout[i*IDXW +: IDXW]} >= CW_LIM) begin
        idx_bad[i]                = 1'b1;
        o_beam_idx[i*IDXW +: IDXW] = IDXW'(i);
      end
    end
  end
`else
  assign o_beam_idx = fifo_dout;
`endif

  // Sticky error flags, cleared by reset or by a slot start.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef BEAM_IDX_CHECK_EN
      o_idx_err   <= 1'b0;
`endif
    end else if (slot_evt) begin
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
`ifdef BEAM_IDX_CHECK_EN
      o_idx_err   <= 1'b0;
`endif
    end else begin
      if (tick_ok && fifo_empty)              o_underflow <= 1'b1;
      if (i_sort_vld && fifo_full && !pop)    o_overflow  <= 1'b1;
`ifdef BEAM_IDX_CHECK_EN
      if (pop_d1 && (|idx_bad))               o_idx_err   <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_beam_idx_sched.sv
// Directed self-checking bench for beam_idx_sched. Inputs change 1 ns after
// the rising edge and outputs are checked at the same point, so each check
// sees the registered result of the preceding edge.
// Build with BEAM_IDX_CHECK_EN defined to cover the index range check.
module tb_beam_idx_sched;
  import pusch_dr_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_cw_tvalid;
  logic          i_slot_start;
  logic          i_sym_start;
  logic          i_rbg_tick;
  logic          i_sort_vld;
  logic [127:0]  i_sort_beam_idx;
  logic          o_sort_rdy;
  logic          o_enable;
  logic [7:0]    o_symb_idx;
  logic          o_symb_clr;
  logic          o_symb_1st;
  logic [127:0]  o_beam_idx;
  logic          o_rbg_load;
  logic          o_underflow;
  logic          o_overflow;
`ifdef BEAM_IDX_CHECK_EN
  logic          o_idx_err;
`endif

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] SEQ_VEC = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] ERR_VEC = 128'h0F0E0D0C0B0A09080706050446020100;

  beam_idx_sched dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_cw_tvalid     (i_cw_tvalid),
    .i_slot_start    (i_slot_start),
    .i_sym_start     (i_sym_start),
    .i_rbg_tick      (i_rbg_tick),
    .i_sort_vld      (i_sort_vld),
    .i_sort_beam_idx (i_sort_beam_idx),
    .o_sort_rdy      (o_sort_rdy),
    .o_enable        (o_enable),
    .o_symb_idx      (o_symb_idx),
    .o_symb_clr      (o_symb_clr),
    .o_symb_1st      (o_symb_1st),
    .o_beam_idx      (o_beam_idx),
    .o_rbg_load      (o_rbg_load),
    .o_underflow     (o_underflow),
    .o_overflow      (o_overflow)
`ifdef BEAM_IDX_CHECK_EN
    ,
    .o_idx_err       (o_idx_err)
`endif
  );

  always #5 i_clk = ~i_clk;

  function automatic beam_idx_vec_t rep(input logic [7:0] k);
    beam_idx_vec_t v;
    for (int i = 0; i < 16; i++) v[i] = k;
    return v;
  endfunction

  task automatic applyStimulus(input logic slot, input logic sym, input logic rbg,
                               input logic vld, input logic [127:0] data);
    i_slot_start    = slot;
    i_sym_start     = sym;
    i_rbg_tick      = rbg;
    i_sort_vld      = vld;
    i_sort_beam_idx = data;
    @(posedge i_clk);
    #1;
    i_slot_start    = 1'b0;
    i_sym_start     = 1'b0;
    i_rbg_tick      = 1'b0;
    i_sort_vld      = 1'b0;
    i_sort_beam_idx = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_reset = 1'b1;
    i_cw_tvalid = 1'b0;
    i_slot_start = 1'b0;
    i_sym_start = 1'b0;
    i_rbg_tick = 1'b0;
    i_sort_vld = 1'b0;
    i_sort_beam_idx = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_enable", o_enable, 0);
    checkOutput("rst_symb_idx", o_symb_idx, 0);
    checkOutput("rst_symb_clr", o_symb_clr, 0);
    checkOutput("rst_symb_1st", o_symb_1st, 1);
    checkOutput("rst_beam_idx", o_beam_idx, 0);
    checkOutput("rst_rbg_load", o_rbg_load, 0);
    checkOutput("rst_underflow", o_underflow, 0);
    checkOutput("rst_overflow", o_overflow, 0);
    checkOutput("rst_sort_rdy", o_sort_rdy, 0);
`ifdef BEAM_IDX_CHECK_EN
    checkOutput("rst_idx_err", o_idx_err, 0);
`endif
    i_reset = 1'b0;

    // LOAD: enable held while the table is not loaded
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 0, 0, 0, '0);
      checkOutput($sformatf("load_enable_%0d", k), o_enable, 1);
    end
    checkOutput("load_sort_rdy", o_sort_rdy, 0);

    // Table loaded -> WAIT
    i_cw_tvalid = 1'b1;
    applyStimulus(0, 0, 0, 0, '0);
    i_cw_tvalid = 1'b0;
    checkOutput("wait_enable", o_enable, 0);
    checkOutput("wait_sort_rdy", o_sort_rdy, 1);
    applyStimulus(0, 0, 1, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("wait_tick_ignored", o_rbg_load, 0);

    // Slot start and symbol counting
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("slot_clr", o_symb_clr, 1);
    checkOutput("slot_idx", o_symb_idx, 0);
    checkOutput("slot_1st", o_symb_1st, 1);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("slot_clr_end", o_symb_clr, 0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 1, 0, 0, '0);
      checkOutput($sformatf("sym_idx_%0d", k), o_symb_idx, k);
      checkOutput($sformatf("sym_1st_%0d", k), o_symb_1st, 1);
    end

    // Tick during fixed phase is ignored
    applyStimulus(0, 0, 0, 1, SEQ_VEC);
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("fix_tick_beam", o_beam_idx, 0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("fix_tick_load", o_rbg_load, 0);

    applyStimulus(0, 1, 0, 0, '0);
    checkOutput("sym_idx_4", o_symb_idx, 4);
    checkOutput("sym_1st_4", o_symb_1st, 0);

    // Tick pops: index at T+1, strobe only at T+2
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("pop_beam_t1", o_beam_idx, SEQ_VEC);
    checkOutput("pop_load_t1", o_rbg_load, 0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("pop_load_t2", o_rbg_load, 1);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("pop_load_t3", o_rbg_load, 0);

    applyStimulus(0, 1, 0, 0, '0);
    checkOutput("sym_idx_5", o_symb_idx, 5);
    repeat (10) applyStimulus(0, 1, 0, 0, '0);
    checkOutput("sym_idx_sat", o_symb_idx, 13);
    checkOutput("sym_1st_sat", o_symb_1st, 0);

    // Tick with empty FIFO
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("uf_beam_hold", o_beam_idx, SEQ_VEC);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("uf_no_load", o_rbg_load, 0);
    checkOutput("uf_flag", o_underflow, 1);

    // Fill to full, overflow, push+pop while full
    for (int k = 1; k <= 16; k++) applyStimulus(0, 0, 0, 1, rep(8'(k)));
    checkOutput("full_rdy", o_sort_rdy, 0);
    checkOutput("full_no_of", o_overflow, 0);
    applyStimulus(0, 0, 0, 1, rep(8'hAA));
    checkOutput("of_flag", o_overflow, 1);
    applyStimulus(0, 0, 1, 1, rep(8'd17));
    checkOutput("pp_beam", o_beam_idx, rep(8'd1));
    checkOutput("pp_still_full", o_sort_rdy, 0);
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("pp_next_beam", o_beam_idx, rep(8'd2));
    checkOutput("pp_rdy", o_sort_rdy, 1);
    checkOutput("pp_load", o_rbg_load, 1);
    for (int k = 3; k <= 17; k++) begin
      applyStimulus(0, 0, 1, 0, '0);
      checkOutput($sformatf("b2b_beam_%0d", k), o_beam_idx, rep(8'(k)));
      checkOutput($sformatf("b2b_load_%0d", k), o_rbg_load, 1);
    end
    applyStimulus(0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("b2b_load_end", o_rbg_load, 0);

    // Slot start clears flags and flushes the FIFO
    applyStimulus(0, 0, 0, 1, rep(8'd5));
    applyStimulus(1, 0, 0, 0, '0);
    checkOutput("clr_uf", o_underflow, 0);
    checkOutput("clr_of", o_overflow, 0);
    repeat (4) applyStimulus(0, 1, 0, 0, '0);
    checkOutput("clr_idx_4", o_symb_idx, 4);
    applyStimulus(0, 0, 1, 0, '0);
    checkOutput("flush_beam_hold", o_beam_idx, rep(8'd17));
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("flush_no_load", o_rbg_load, 0);
    checkOutput("flush_uf", o_underflow, 1);

    // Out-of-range index at beam 3
    applyStimulus(0, 0, 0, 1, ERR_VEC);
    applyStimulus(0, 0, 1, 0, '0);
`ifdef BEAM_IDX_CHECK_EN
    checkOutput("idx_replaced", o_beam_idx, SEQ_VEC);
`else
    checkOutput("idx_passthru", o_beam_idx, ERR_VEC);
`endif
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("idx_load", o_rbg_load, 1);
`ifdef BEAM_IDX_CHECK_EN
    checkOutput("idx_err", o_idx_err, 1);
`endif

    // Asynchronous reset mid-RUN
    i_reset = 1'b1;
    #2;
    checkOutput("mid_rst_enable", o_enable, 0);
    checkOutput("mid_rst_1st", o_symb_1st, 1);
    checkOutput("mid_rst_beam", o_beam_idx, 0);
    checkOutput("mid_rst_uf", o_underflow, 0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    applyStimulus(0, 0, 0, 0, '0);
    checkOutput("mid_rst_reload", o_enable, 1);
    checkOutput("mid_rst_rdy", o_sort_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
